// File: rtl/interrupt_controller.sv
// Prioritising interrupt controller feeding int_sig/vector to the multicycle CPU control FSM.
// Optional build macro INTC_LEVEL_TRIG_EN selects level-sensitive pending instead of edge latching.
module interrupt_controller #(
    parameter int unsigned      N_IRQ     = 8,
    parameter logic [31:0]      VEC_BASE  = 32'h0000_0080,
    parameter int unsigned      VEC_SHIFT = 4,
    parameter logic [N_IRQ-1:0] MASK_RST  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             int_ack,
    input  logic             int_done,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pending,
    output logic             int_sig,
    output logic [4:0]       int_id,
    output logic [31:0]      vector
);

    localparam int unsigned ID_W  = 5;
    localparam int unsigned VEC_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              int_sig_nxt;
    logic [ID_W-1:0]   int_id_nxt;
    logic [VEC_W-1:0]  vector_nxt;
    logic              ack_clr;

    logic [N_IRQ-1:0]  s1, s2;
    logic [N_IRQ-1:0]  req;
    logic [N_IRQ-1:0]  sel;
    logic [N_IRQ-1:0]  pending_nxt;
    logic              sel_enabled;
    logic [ID_W-1:0]   req_id;

    // Lowest set index wins; zero when nothing is set.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

`ifdef INTC_LEVEL_TRIG_EN
    // Two-flop synchroniser; pending simply follows the synchronised level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
        end
    end

    assign pending_nxt = s2;
`else
    logic [N_IRQ-1:0] s3;

    // Two-flop synchroniser plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A new edge on the line being acknowledged keeps the bit set.
    assign pending_nxt = (pending & ~(ack_clr ? sel : '0)) | (s2 & ~s3);
`endif

    assign req         = pending & mask;
    assign req_id      = lowest_idx(req);
    assign sel         = N_IRQ'(1) << int_id;
    assign sel_enabled = |(mask & sel);

    // Mask and pending status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask    <= MASK_RST;
            pending <= '0;
        end else begin
            if (mask_we) mask <= mask_wdata;
            pending <= pending_nxt;
        end
    end

    // FSM state and registered request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            int_sig <= 1'b0;
            int_id  <= '0;
            vector  <= VEC_BASE;
        end else begin
            state   <= state_nxt;
            int_sig <= int_sig_nxt;
            int_id  <= int_id_nxt;
            vector  <= vector_nxt;
        end
    end

    // Next state: latch in IDLE, hold in REQ until ack or withdrawal, wait for RFE in SERVICE.
    always_comb begin
        state_nxt   = state;
        int_sig_nxt = int_sig;
        int_id_nxt  = int_id;
        vector_nxt  = vector;
        ack_clr     = 1'b0;

        case (state)
            IDLE: begin
                int_sig_nxt = 1'b0;
                if (|req) begin
                    int_id_nxt  = req_id;
                    vector_nxt  = VEC_BASE + (VEC_W'(req_id) << VEC_SHIFT);
                    int_sig_nxt = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                int_sig_nxt = 1'b1;
                if (int_ack) begin
                    ack_clr     = 1'b1;
                    int_sig_nxt = 1'b0;
                    state_nxt   = SERVICE;
                end else if (!sel_enabled) begin
                    int_sig_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            SERVICE: begin
                int_sig_nxt = 1'b0;
                if (int_done) state_nxt = IDLE;
            end
            default: begin
                int_sig_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Prioritising interrupt controller that sits directly upstream of the multicycle CPU control FSM. It produces the single int_sig request that the FSM samples in FETCH. It supplies the handler vector that is loaded into PC when pc_source selects the interrupt vector. It tracks the acknowledge/return handshake so only one interrupt is in service at a time.

Parameters:
N_IRQ, 8, number of external interrupt lines (1..32)
VEC_BASE, 32'h0000_0080, vector address of line 0
VEC_SHIFT, 4, vector = VEC_BASE + (id << VEC_SHIFT)
MASK_RST, all ones, reset value of the enable mask

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-low reset
irq_in  in  N_IRQ  external interrupt lines, asynchronous, active-high
int_ack  in  1  CPU entered INTERRUPT state (one-cycle pulse, driven from int_save_pc)
int_done  in  1  CPU executed RFE (one-cycle pulse)
mask_we  in  1  write enable for mask register
mask_wdata  in  N_IRQ  new mask value
mask  out  N_IRQ  current enable mask (1 = enabled)
pending  out  N_IRQ  latched pending bits, status read
int_sig  out  1  interrupt request to control unit, registered
int_id  out  5  index of the latched/in-service line
vector  out  32  handler address for int_id, registered

Behaviour:
- Reset (rst=0, async): sync/edge flops=0, pending=0, mask=MASK_RST, state=IDLE, int_sig=0, int_id=0, vector=VEC_BASE.
- Input path: each irq_in bit passes through a 2-flop synchroniser (s1, s2) and then a delay flop s3. Rising edge = s2 & ~s3. The matching pending bit is set on the next posedge.
- Latency: irq_in rises before posedge k → s1 at k, s2 at k+1, pending at k+2, int_sig=1 at k+3 (when IDLE and enabled).
- Request vector req = pending & mask. Priority: lowest index wins.
- mask_we: mask <= mask_wdata on posedge, in any state. Masking does not clear pending.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if req != 0, latch int_id = lowest set index, latch vector = VEC_BASE + (int_id << VEC_SHIFT), set int_sig=1, go to REQ. Otherwise hold. int_ack and int_done are ignored.
  - REQ: int_sig held at 1; int_id and vector are frozen.
    - On int_ack: clear pending[int_id], int_sig=0, go to SERVICE.
    - If mask[int_id] becomes 0 with no int_ack in the same cycle: int_sig=0, go to IDLE (request withdrawn, pending kept).
    - A higher-priority arrival does not preempt a latched request.
    - int_done is ignored.
  - SERVICE: int_sig=0. New edges keep setting pending. On int_done go to IDLE. The next request can raise int_sig on the following cycle. int_ack is ignored (no nesting).
- Simultaneous set and clear of the same pending bit (new edge in the same cycle as the int_ack clear): set wins, bit stays 1.
- Vector arithmetic is 32-bit, and overflow wraps.
- int_id is zero-extended to 5 bits.
- Reset mid-REQ or mid-SERVICE: returns to reset values immediately. Any lost request must be re-raised by a new edge.

Optional Feature:
- Macro: INTC_LEVEL_TRIG_EN.
- Defined: pending[i] = s2[i] (level-sensitive, no latching). The int_ack clear has no effect; the source must deassert its line before int_done. s3 flops are removed.
- Undefined: edge-triggered latching exactly as described above.

Test Plan:
- Reset: rst low mid-REQ with int_sig=1 → int_sig, pending=0 at once; mask=8'hFF after release.
- Single line: irq_in[3] rises before edge 0 → int_sig=1 at edge 3, int_id=3, vector=0x0000_00B0. int_ack pulse → int_sig=0, pending[3]=0. int_done → IDLE.
- Priority: irq_in[5] and irq_in[2] rise together → int_id=2, vector=0xA0. After int_done, the next request shows int_id=5, vector=0xD0 one cycle after IDLE.
- Mask: mask_wdata=8'hF7 while line 3 is in REQ → int_sig drops the next cycle, pending[3] stays 1. Restoring mask=8'hFF → request reissued.
- Set-wins collision: new edge on line 1 detected in the same cycle as int_ack for line 1 → pending[1]=1 after the ack. Next request is raised after int_done.
- No nesting: irq_in[0] rises during SERVICE of line 4 → int_sig stays 0 until int_done, then int_id=0.
